decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 32, datapath/PC width; SHALL be >= 32.
- REG_N, 32, register-file depth, power of two.
- REG_W, 5, register address width, equal to log2(REG_N).
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_clk, in, 1, single clock, rising-edge.
- i_reset, in, 1, asynchronous active-low reset.
- i_valid_D, in, 1, instruction in decode is valid.
- i_instruction_D, in, 32, fetched instruction.
- i_npc_D, in, DATA_W, next PC (PC+4).
- i_stall_HU, in, 1, hazard unit stall.
- i_flush_HU, in, 1, hazard unit flush.
- i_forward_a_FU, in, 2, rs operand forward select.
- i_forward_b_FU, in, 2, rt operand forward select.
- i_alu_result_M, in, DATA_W, MEM-stage ALU result.
- i_reg_write_W, in, 1, write-back enable.
- i_write_register_W, in, REG_W, write-back address.
- i_write_data_W, in, DATA_W, write-back data.
- i_branch_MC, in, 1, conditional branch.
- i_branch_ne_MC, in, 1, 1 = BNE, 0 = BEQ.
- i_jump_MC, in, 1, unconditional jump.
- o_pc_src_D, out, 1, redirect fetch.
- o_target_addr_D, out, DATA_W, redirect address.
- o_valid_E, out, 1, ID/EX entry valid.
- o_read_data_1_E, out, DATA_W, rs operand, registered.
- o_read_data_2_E, out, DATA_W, rt operand, registered.
- o_imm_ext_E, out, DATA_W, sign-extended instr[15:0], registered.
- o_rs_E, o_rt_E, o_rd_E, out, 5 each, instr[25:21], [20:16], [15:11], registered.
- o_taken_cnt, out, 16, redirect event counter.

Function
REQ-003 Register file SHALL hold REG_N x DATA_W entries; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-004 Register write SHALL occur on the rising edge when i_reg_write_W=1 and i_write_register_W!=0.
REQ-005 Register reads SHALL be combinational on instr[25:21] and instr[20:16], with internal bypass: if i_reg_write_W=1, the address is nonzero and equals i_write_register_W, the read SHALL return i_write_data_W in the same cycle.
REQ-006 Forward select SHALL map 00 to the register file, 01 to i_alu_result_M, 10 to i_write_data_W, and 11 to the register file (reserved).
REQ-007 eq SHALL be 1 when the forwarded operands are equal over the full DATA_W.
REQ-008 The active condition SHALL be i_valid_D & ~i_stall_HU.
REQ-009 o_pc_src_D SHALL be active & (i_jump_MC | (i_branch_MC & (eq ^ i_branch_ne_MC))), combinational.
REQ-010 Jump target SHALL be {i_npc_D[DATA_W-1:28], instr[25:0], 2'b00}.
REQ-011 Branch target SHALL be i_npc_D + (sign-extended imm << 2), modulo 2^DATA_W.
REQ-012 When i_jump_MC and i_branch_MC are both 1, the jump target SHALL win; o_target_addr_D SHALL be the branch target whenever the jump is not selected.
REQ-013 ID/EX register update on the rising edge SHALL follow this priority: flush (all registered outputs 0, o_valid_E=0) > stall (hold all) > load (o_valid_E=i_valid_D, operands and fields from the current cycle).
REQ-014 The ID/EX register latency SHALL be one cycle from decode inputs to _E outputs.
REQ-015 o_taken_cnt SHALL increment by 1 on each rising edge with o_pc_src_D=1 and SHALL saturate at 0xFFFF.
REQ-016 o_taken_cnt SHALL be unaffected by stall and flush.

Reset
REQ-017 i_reset=0 SHALL asynchronously clear all register-file entries, all _E outputs, o_valid_E, and o_taken_cnt to 0.
REQ-018 Reset mid-operation SHALL discard any in-flight write.
REQ-019 After i_reset returns to 1, state SHALL be written on the first rising edge.
REQ-020 o_pc_src_D SHALL be 0 during reset while i_valid_D=0.

Verification
REQ-021 Write r5=0x1234 and, in the same cycle, decode rs=5 with forward=00 -> o_read_data_1_E=0x00001234 on the next edge.
REQ-022 Write r0=0xFFFFFFFF, then read r0 -> 0.
REQ-023 BEQ with r1=r2=7, npc=0x100, imm=0xFFFF -> o_pc_src_D=1, target=0x000000FC.
REQ-024 BNE with the same operands -> o_pc_src_D=0.
REQ-025 BEQ with forward_a=01, i_alu_result_M=9, r2=9 -> taken.
REQ-026 Stall and flush asserted together -> o_valid_E=0, _E outputs 0, o_pc_src_D=0.
REQ-027 Stall alone -> _E outputs hold for 3 cycles.
REQ-028 Jump with instr[25:0]=0x3FFFFFF, npc=0xA0000000 -> target=0xAFFFFFFC.
REQ-029 Jump and branch asserted together -> the jump target wins.
REQ-030 Force 65537 taken events -> o_taken_cnt=0xFFFF.
REQ-031 Assert i_reset low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_if.sv
// Decode-stage signal bundle: fetch/hazard/forward/write-back inputs toward the
// decode stage, and redirect plus ID/EX pipeline outputs back out of it.
interface decode_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              i_valid_D;
  logic [31:0]       i_instruction_D;
  logic [DATA_W-1:0] i_npc_D;
  logic              i_stall_HU;
  logic              i_flush_HU;
  logic [1:0]        i_forward_a_FU;
  logic [1:0]        i_forward_b_FU;
  logic [DATA_W-1:0] i_alu_result_M;
  logic              i_reg_write_W;
  logic [REG_W-1:0]  i_write_register_W;
  logic [DATA_W-1:0] i_write_data_W;
  logic              i_branch_MC;
  logic              i_branch_ne_MC;
  logic              i_jump_MC;
  logic              o_pc_src_D;
  logic [DATA_W-1:0] o_target_addr_D;
  logic              o_valid_E;
  logic [DATA_W-1:0] o_read_data_1_E;
  logic [DATA_W-1:0] o_read_data_2_E;
  logic [DATA_W-1:0] o_imm_ext_E;
  logic [4:0]        o_rs_E;
  logic [4:0]        o_rt_E;
  logic [4:0]        o_rd_E;
  logic [15:0]       o_taken_cnt;

  // Handshake: i_valid_D qualifies the decode slot; i_stall_HU acts as the
  // not-ready back-pressure, so an instruction is consumed only when
  // i_valid_D & ~i_stall_HU, and o_valid_E marks a loaded ID/EX entry.
  modport master (
    output i_valid_D, i_instruction_D, i_npc_D, i_stall_HU, i_flush_HU,
           i_forward_a_FU, i_forward_b_FU, i_alu_result_M, i_reg_write_W,
           i_write_register_W, i_write_data_W, i_branch_MC, i_branch_ne_MC,
           i_jump_MC,
    input  o_pc_src_D, o_target_addr_D, o_valid_E, o_read_data_1_E,
           o_read_data_2_E, o_imm_ext_E, o_rs_E, o_rt_E, o_rd_E, o_taken_cnt
  );

  modport slave (
    input  i_valid_D, i_instruction_D, i_npc_D, i_stall_HU, i_flush_HU,
           i_forward_a_FU, i_forward_b_FU, i_alu_result_M, i_reg_write_W,
           i_write_register_W, i_write_data_W, i_branch_MC, i_branch_ne_MC,
           i_jump_MC,
    output o_pc_src_D, o_target_addr_D, o_valid_E, o_read_data_1_E,
           o_read_data_2_E, o_imm_ext_E, o_rs_E, o_rt_E, o_rd_E, o_taken_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS-style decode stage: register file with write-through bypass, operand
// forwarding, early branch/jump resolution, ID/EX register and redirect counter.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int REG_W  = 5
) (
  input logic     i_clk,
  input logic     i_reset,
  decode_if.slave dif
);

  logic [DATA_W-1:0] rf [REG_N];
  logic [REG_W-1:0]  rs_a;
  logic [REG_W-1:0]  rt_a;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] br_tgt;
  logic [DATA_W-1:0] jmp_tgt;
  logic              eq;
  logic              active;
  logic              wr_en;
  logic              unused_opcode;

  assign rs_a          = dif.i_instruction_D[21 +: REG_W];
  assign rt_a          = dif.i_instruction_D[16 +: REG_W];
  assign wr_en         = dif.i_reg_write_W && (dif.i_write_register_W != '0);
  assign unused_opcode = ^dif.i_instruction_D[31:26];

  // Write-through bypass makes a same-cycle write visible to the reader.
  always_comb begin
    rf_a = rf[rs_a];
    rf_b = rf[rt_a];
    if (rs_a == '0)
      rf_a = '0;
    else if (wr_en && (dif.i_write_register_W == rs_a))
      rf_a = dif.i_write_data_W;
    if (rt_a == '0)
      rf_b = '0;
    else if (wr_en && (dif.i_write_register_W == rt_a))
      rf_b = dif.i_write_data_W;
  end

  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
    case (dif.i_forward_a_FU)
      2'b01:   op_a = dif.i_alu_result_M;
      2'b10:   op_a = dif.i_write_data_W;
      default: op_a = rf_a;
    endcase
    case (dif.i_forward_b_FU)
      2'b01:   op_b = dif.i_alu_result_M;
      2'b10:   op_b = dif.i_write_data_W;
      default: op_b = rf_b;
    endcase
  end

  assign imm_ext = {{(DATA_W-16){dif.i_instruction_D[15]}}, dif.i_instruction_D[15:0]};
  assign br_tgt  = dif.i_npc_D + (imm_ext << 2);
  assign jmp_tgt = {dif.i_npc_D[DATA_W-1:28], dif.i_instruction_D[25:0], 2'b00};
  assign eq      = (op_a == op_b);
  assign active  = dif.i_valid_D && !dif.i_stall_HU;

  assign dif.o_pc_src_D      = active && (dif.i_jump_MC ||
                               (dif.i_branch_MC && (eq ^ dif.i_branch_ne_MC)));
  assign dif.o_target_addr_D = dif.i_jump_MC ? jmp_tgt : br_tgt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[dif.i_write_register_W] <= dif.i_write_data_W;
    end
  end

  // Flush outranks stall so a squashed slot never lingers while frozen.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      dif.o_valid_E       <= 1'b0;
      dif.o_read_data_1_E <= '0;
      dif.o_read_data_2_E <= '0;
      dif.o_imm_ext_E     <= '0;
      dif.o_rs_E          <= '0;
      dif.o_rt_E          <= '0;
      dif.o_rd_E          <= '0;
    end else if (dif.i_flush_HU) begin
      dif.o_valid_E       <= 1'b0;
      dif.o_read_data_1_E <= '0;
      dif.o_read_data_2_E <= '0;
      dif.o_imm_ext_E     <= '0;
      dif.o_rs_E          <= '0;
      dif.o_rt_E          <= '0;
      dif.o_rd_E          <= '0;
    end else if (!dif.i_stall_HU) begin
      dif.o_valid_E       <= dif.i_valid_D;
      dif.o_read_data_1_E <= op_a;
      dif.o_read_data_2_E <= op_b;
      dif.o_imm_ext_E     <= imm_ext;
      dif.o_rs_E          <= dif.i_instruction_D[25:21];
      dif.o_rt_E          <= dif.i_instruction_D[20:16];
      dif.o_rd_E          <= dif.i_instruction_D[15:11];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      dif.o_taken_cnt <= '0;
    else if (dif.o_pc_src_D && (dif.o_taken_cnt != 16'hFFFF))
      dif.o_taken_cnt <= dif.o_taken_cnt + 16'd1;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand sequences
// for multi-cycle corners, and random traffic against a behavioural model.
module tb_decode_stage;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int RW = 5;
  localparam int EW = 1 + 3*DW + 15;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] alu;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        branch;
    logic        bne;
    logic        jump;
    logic        exp_pc;
    logic [31:0] exp_tgt;
    logic        chk_tgt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_if #(.DATA_W(DW), .REG_W(RW)) dif ();
  decode_stage #(.DATA_W(DW), .REG_N(RN), .REG_W(RW)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .dif     (dif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0]   m_regs [RN];
  logic [EW-1:0] m_e;
  int            m_cnt;
  logic [EW-1:0] exp_q[$];
  vec_t          tbl [13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] dut_e();
    return {dif.o_valid_E, dif.o_read_data_1_E, dif.o_read_data_2_E, dif.o_imm_ext_E,
            dif.o_rs_E, dif.o_rt_E, dif.o_rd_E};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (dif.i_reg_write_W && dif.i_write_register_W == a) return dif.i_write_data_W;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd1) return dif.i_alu_result_M;
    if (sel == 2'd2) return dif.i_write_data_W;
    return rf;
  endfunction

  task automatic drive(input vec_t v);
    dif.i_valid_D          = v.valid;
    dif.i_instruction_D    = v.instr;
    dif.i_npc_D            = v.npc;
    dif.i_stall_HU         = v.stall;
    dif.i_flush_HU         = v.flush;
    dif.i_forward_a_FU     = v.fa;
    dif.i_forward_b_FU     = v.fb;
    dif.i_alu_result_M     = v.alu;
    dif.i_reg_write_W      = v.we;
    dif.i_write_register_W = v.wa;
    dif.i_write_data_W     = v.wd;
    dif.i_branch_MC        = v.branch;
    dif.i_branch_ne_MC     = v.bne;
    dif.i_jump_MC          = v.jump;
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{0, 32'h0, 32'h0, 0, 0, 2'd0, 2'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0, 32'h0, 0};
    return v;
  endfunction

  // One decode cycle: predict redirect and next ID/EX contents, clock, compare.
  task automatic cycle(input vec_t v, input bit tbl_chk);
    logic [31:0] a, b, imm, tgt;
    logic        taken;
    drive(v);
    #1;
    a     = m_fwd(v.fa, m_read(v.instr[25:21]));
    b     = m_fwd(v.fb, m_read(v.instr[20:16]));
    imm   = 32'($signed(v.instr[15:0]));
    taken = v.valid && !v.stall && (v.jump || (v.branch && ((a == b) != v.bne)));
    tgt   = v.jump ? {v.npc[31:28], v.instr[25:0], 2'b00} : v.npc + imm * 32'd4;
    chk("pc_src_model", dif.o_pc_src_D, taken);
    chk("target_model", dif.o_target_addr_D, tgt);
    if (tbl_chk) begin
      chk("pc_src_table", dif.o_pc_src_D, v.exp_pc);
      if (v.chk_tgt) chk("target_table", dif.o_target_addr_D, v.exp_tgt);
    end
    if (v.flush)      exp_q.push_back('0);
    else if (v.stall) exp_q.push_back(m_e);
    else exp_q.push_back({v.valid, a, b, imm, v.instr[25:21], v.instr[20:16], v.instr[15:11]});
    @(posedge clk);
    #1;
    m_e = exp_q.pop_front();
    if (v.we && v.wa != 5'd0) m_regs[v.wa] = v.wd;
    if (taken && m_cnt < 65535) m_cnt++;
    chk("id_ex_bundle", dut_e(), m_e);
    chk("taken_cnt", dif.o_taken_cnt, m_cnt[15:0]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < RN; i++) m_regs[i] = 32'd0;
    m_e   = '0;
    m_cnt = 0;
  endtask

  initial begin
    vec_t v;
    logic [EW-1:0] saved;
    model_reset();
    drive(idle_vec());

    #12;
    chk("reset_bundle", dut_e(), '0);
    chk("reset_cnt", dif.o_taken_cnt, 16'h0);
    chk("reset_pc_src", dif.o_pc_src_D, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preload r1=7, r2=7, r3=9.
    v = idle_vec(); v.we = 1; v.wa = 5'd1; v.wd = 32'd7; cycle(v, 0);
    v.wa = 5'd2; cycle(v, 0);
    v.wa = 5'd3; v.wd = 32'd9; cycle(v, 0);

    //           valid instr         npc            st fl fa fb alu we wa wd br bne jmp exp_pc exp_tgt chk
    tbl[0]  = '{1, 32'h1022FFFF, 32'h00000100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h000000FC, 1};
    tbl[1]  = '{1, 32'h1022FFFF, 32'h00000100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h000000FC, 1};
    tbl[2]  = '{1, 32'h10230010, 32'h00000200, 0, 0, 1, 0, 9, 0, 0, 0, 1, 0, 0, 1, 32'h00000240, 1};
    tbl[3]  = '{1, 32'h10230010, 32'h00000200, 0, 0, 1, 0, 8, 0, 0, 0, 1, 0, 0, 0, 32'h00000240, 1};
    tbl[4]  = '{1, 32'h10220001, 32'h00000300, 0, 0, 2, 0, 0, 0, 0, 7, 1, 0, 0, 1, 32'h00000304, 1};
    tbl[5]  = '{1, 32'h10220001, 32'h00000300, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h00000304, 1};
    tbl[6]  = '{1, 32'h0BFFFFFF, 32'hA0000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hAFFFFFFC, 1};
    tbl[7]  = '{1, 32'h1022FFFF, 32'h00000100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h008BFFFC, 1};
    tbl[8]  = '{0, 32'h0BFFFFFF, 32'hA0000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hAFFFFFFC, 1};
    tbl[9]  = '{1, 32'h1022FFFF, 32'h00000100, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h000000FC, 1};
    tbl[10] = '{1, 32'h1022FFFF, 32'h00000100, 0, 0, 0, 0, 0, 1, 1, 5, 1, 0, 0, 0, 32'h000000FC, 1};
    tbl[11] = '{1, 32'h1022FFFF, 32'h00000100, 0, 0, 0, 2, 0, 0, 0, 5, 1, 1, 0, 0, 32'h000000FC, 1};
    tbl[12] = '{1, 32'h10220008, 32'hFFFFFFF0, 0, 0, 1, 0, 7, 0, 0, 0, 1, 0, 0, 1, 32'h00000010, 1};
    for (int i = 0; i < 13; i++) cycle(tbl[i], 1);

    // Same-cycle write and read of r5.
    v = idle_vec(); v.valid = 1; v.instr = 32'h00A00000; v.we = 1; v.wa = 5'd5; v.wd = 32'h1234;
    cycle(v, 0);
    chk("bypass_rd1", dif.o_read_data_1_E, 32'h00001234);

    // Writes to r0 are ignored.
    v = idle_vec(); v.we = 1; v.wa = 5'd0; v.wd = 32'hFFFFFFFF; cycle(v, 0);
    v = idle_vec(); v.valid = 1; cycle(v, 0);
    chk("r0_rd1", dif.o_read_data_1_E, 32'h0);
    chk("r0_rd2", dif.o_read_data_2_E, 32'h0);

    // Stall + flush together.
    v = idle_vec(); v.valid = 1; v.instr = 32'h1022FFFF; v.npc = 32'h100; v.branch = 1;
    v.stall = 1; v.flush = 1; v.exp_pc = 0;
    cycle(v, 1);
    chk("flush_valid", dif.o_valid_E, 1'b0);
    chk("flush_bundle", dut_e(), '0);

    // Stall holds the loaded entry for 3 cycles.
    v = idle_vec(); v.valid = 1; v.instr = 32'h1022FFFF; v.npc = 32'h100;
    cycle(v, 0);
    saved = m_e;
    for (int i = 0; i < 3; i++) begin
      v = idle_vec(); v.valid = 1; v.stall = 1; v.instr = $urandom; v.alu = $urandom;
      cycle(v, 0);
      chk("stall_hold", dut_e(), saved);
    end

    for (int i = 0; i < 400; i++) begin
      v = idle_vec();
      v.valid  = 1'($urandom_range(0, 3) != 0);
      v.stall  = 1'($urandom_range(0, 7) == 0);
      v.flush  = 1'($urandom_range(0, 7) == 0);
      v.fa     = 2'($urandom_range(0, 3));
      v.fb     = 2'($urandom_range(0, 3));
      v.alu    = 32'($urandom_range(0, 3));
      v.we     = 1'($urandom_range(0, 1));
      v.wa     = 5'($urandom_range(0, 7));
      v.wd     = 32'($urandom_range(0, 3));
      v.instr  = {$urandom} & 32'hFCE7FFFF;
      v.npc    = $urandom;
      v.branch = 1'($urandom_range(0, 1));
      v.bne    = 1'($urandom_range(0, 1));
      v.jump   = 1'($urandom_range(0, 4) == 0);
      cycle(v, 0);
    end

    // Saturation of the redirect counter.
    v = idle_vec(); v.valid = 1; v.jump = 1; v.instr = 32'h08000010;
    drive(v);
    repeat (65537) @(posedge clk);
    #1;
    chk("cnt_saturate", dif.o_taken_cnt, 16'hFFFF);
    m_cnt = 65535;
    cycle(v, 0);

    // Asynchronous reset mid-stream discards state, including r6.
    v = idle_vec(); v.valid = 1; v.instr = 32'h10C20000; v.we = 1; v.wa = 5'd6; v.wd = 32'hAA;
    cycle(v, 0);
    v = idle_vec(); v.valid = 1; v.instr = 32'h00C00000; v.we = 1; v.wa = 5'd6; v.wd = 32'hAA;
    cycle(v, 0);
    dif.i_valid_D = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_bundle", dut_e(), '0);
    chk("async_rst_cnt", dif.o_taken_cnt, 16'h0);
    chk("async_rst_pc_src", dif.o_pc_src_D, 1'b0);
    model_reset();
    dif.i_reg_write_W = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = idle_vec(); v.valid = 1; v.instr = 32'h00C00000;
    cycle(v, 0);
    chk("rst_r6_cleared", dif.o_read_data_1_E, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
